// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, runs the imem req/ack
// handshake and presents one instruction at a time to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        ifid_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_out_valid;
  logic        w_can_issue;

  assign w_can_issue = !r_out_valid || ifid_write;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_fetch_pc;
    if (r_state == S_RUN) begin
      imem_req = w_can_issue && !redirect;
    end else begin
      imem_req  = 1'b1;
      imem_addr = r_req_addr;
    end
    // The memory side is reset with us; never present a request during reset.
    if (rst) imem_req = 1'b0;
  end

  assign pc          = r_out_valid ? r_out_pc    : 32'h0;
  assign rdata       = r_out_valid ? r_out_instr : 32'h0;
  assign fetch_valid = r_out_valid;

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_fetch_pc  <= RESET_PC;
      r_req_addr  <= 32'h0;
      r_out_pc    <= 32'h0;
      r_out_instr <= 32'h0;
      r_out_valid <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc  <= redirect_pc;
      r_out_valid <= 1'b0;
      if (r_state != S_RUN) begin
        r_state <= imem_ack ? S_RUN : S_DISCARD;
      end
    end else begin
      // Drain first; a capture below at the same edge overrides it.
      if (ifid_write) r_out_valid <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_can_issue) begin
            r_req_addr <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (imem_ack) begin
              r_out_pc    <= r_fetch_pc;
              r_out_instr <= imem_rdata;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            r_out_pc    <= r_req_addr;
            r_out_instr <= imem_rdata;
            r_out_valid <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_DISCARD: begin
          if (imem_ack) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
